mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Sequences the CPU's single byte-wide memory bus (mem_a/mem_dout/mem_wr/mem_din) between two requesters:
//  instruction fetch (4-byte reads) and load/store unit (1/2/4-byte reads or writes). Sits inside cpu, and its
//  bus outputs are the CPU memory port. Splits each access into byte beats, absorbs the 1-cycle synchronous RAM
//  read latency, assembles little-endian words, and restarts a transfer after a debug stall (rdy_in low).
// PARAMETERS
//  ADDR_WIDTH  32  width of all address ports
// PORTS
//  clk_in         in   1   system clock
//  rst_n_in       in   1   asynchronous, active-low reset
//  rdy_in         in   1   1 = bus owned by CPU; 0 = debug host owns bus, controller frozen
//  mem_din        in   8   read byte from RAM/IO, valid the cycle after its address was driven
//  mem_dout       out  8   write byte
//  mem_a          out  32  byte address
//  mem_wr         out  1   1 = write mem_dout to mem_a this cycle
//  if_req_in      in   1   fetch request; held with if_addr_in stable until if_done_out
//  if_addr_in     in   32  fetch address (word aligned)
//  if_flush_in    in   1   abort any fetch in progress (redirect)
//  if_done_out    out  1   1-cycle pulse: if_data_out valid
//  if_data_out    out  32  fetched instruction
//  lsu_req_in     in   1   data request; held with its fields stable until lsu_done_out
//  lsu_wr_in      in   1   1 = store, 0 = load
//  lsu_size_in    in   2   0 = byte, 1 = half, 2 = word (3 reserved, treated as word)
//  lsu_addr_in    in   32  data address
//  lsu_wdata_in   in   32  store data, byte k = bits [8k+7:8k]
//  lsu_done_out   out  1   1-cycle pulse: load data valid / store complete
//  lsu_rdata_out  out  32  load data, zero-extended (sign extension belongs to the LSU)
// BEHAVIOUR
//  Reset: state IDLE, beat counters 0, mem_wr/mem_dout/mem_a/if_done_out/lsu_done_out/data outputs 0,
//   last_grant = LSU. Asynchronous assertion mid-transfer aborts it immediately (mem_wr drops with reset).
//  All outputs are registered. States: IDLE -> RD | WR -> DONE -> IDLE.
//  Arbitration in IDLE (rdy_in=1): only one request -> grant it. Both -> grant the one not in last_grant
//   (round robin). last_grant is updated at grant.
//  Read of n bytes (fetch n=4), request sampled in cycle 0: mem_a = A+k in cycle 1+k (k<n), mem_wr=0;
//   byte k on mem_din in cycle 2+k, captured at end of that cycle; mem_a holds A+n-1 after the last issue.
//   DONE in cycle n+2 with done pulse and data valid (word: cycle 6, byte: cycle 3).
//  Write of n bytes: mem_wr=1, mem_a=A+k, mem_dout=wdata byte k in cycles 1..n; mem_wr=0 and lsu_done_out=1
//   in cycle n+1 (DONE).
//  DONE lasts exactly 1 cycle, and requests are ignored in it. Earliest new grant is sampled in cycle n+3 (read) /
//   n+2 (write). Requester drops or changes req in the done cycle.
//  Addresses increment by full 32-bit add (0xFFFFFFFF+1 wraps to 0). No alignment check.
//  IO region (addr[17:16]==2'b11) reads are side-effecting. The LSU issues only byte accesses there.
//   The controller does not special-case them.
//  rdy_in=0: at next edge mem_wr<=0, beat counter<=0, captured bytes discarded, state/grant held. When
//   rdy_in returns to 1, the granted transfer restarts from byte 0 with the same timing as a fresh grant.
//   Repeated write beats are idempotent. In IDLE no grant occurs while rdy_in=0.
//  if_flush_in=1: if state is RD for fetch, return to IDLE at next edge with no if_done_out, even if the
//   last byte is arriving that cycle. Ungranted fetch request is not latched. LSU transfers are unaffected.
//   Flush in DONE for fetch: the pulse still occurs and the fetch unit discards it.
//  Flush and rdy_in=0 together: flush wins (IDLE).
// TESTING
//  Word fetch A=0x100, RAM bytes 13,05,00,00 -> mem_a 0x100..0x103 in cycles 1-4; if_done cycle 6, data 0x00000513.
//  Store word 0xDEADBEEF @0x200 -> mem_wr=1 cycles 1-4 bytes EF,BE,AD,DE at 0x200..0x203; lsu_done cycle 5.
//  if_req and lsu_req (byte load @0x1000) both high after reset -> fetch granted first, then load.
//   Repeat both -> grants alternate; no requester waits for more than one other transfer.
//  rdy_in low for 3 cycles during beat 2 of word load -> restart at A+0 after release; correct data, single done.
//  Flush during fetch beat 3 -> no if_done_out, IDLE next cycle, pending lsu_req granted immediately.
//  rst_n_in low mid-write -> mem_wr=0 asynchronously, all outputs 0; first request after release behaves as fresh.

Source files
------------

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//   Sequences the CPU's single byte-wide memory bus between the instruction
//   fetch unit (4-byte reads) and the load/store unit (1/2/4-byte reads or
//   writes). Each access is split into byte beats. The 1-cycle synchronous
//   RAM read latency is absorbed, and read bytes are assembled into a
//   little-endian word. A transfer that is interrupted by a debug stall
//   (rdy_in low) restarts from its first byte.
//
// Ports
//   clk_in         system clock
//   rst_n_in       asynchronous active-low reset
//   rdy_in         1 = CPU owns the bus, 0 = debug host owns it (frozen)
//   mem_din        read byte, valid the cycle after its address was driven
//   mem_dout       write byte
//   mem_a          byte address
//   mem_wr         1 = write mem_dout to mem_a this cycle
//   if_req_in      fetch request, held with if_addr_in until if_done_out
//   if_addr_in     fetch address (word aligned)
//   if_flush_in    abort a fetch in progress
//   if_done_out    1-cycle pulse, if_data_out valid
//   if_data_out    fetched instruction
//   lsu_req_in     data request, held with its fields until lsu_done_out
//   lsu_wr_in      1 = store, 0 = load
//   lsu_size_in    0 = byte, 1 = half, 2/3 = word
//   lsu_addr_in    data address
//   lsu_wdata_in   store data, byte k = bits [8k+7:8k]
//   lsu_done_out   1-cycle pulse, load data valid / store complete
//   lsu_rdata_out  load data, zero-extended
// ---------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  if_req_in,
   input  logic [ADDR_WIDTH-1:0] if_addr_in,
   input  logic                  if_flush_in,
   output logic                  if_done_out,
   output logic [31:0]           if_data_out,
   input  logic                  lsu_req_in,
   input  logic                  lsu_wr_in,
   input  logic [1:0]            lsu_size_in,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_in,
   input  logic [31:0]           lsu_wdata_in,
   output logic                  lsu_done_out,
   output logic [31:0]           lsu_rdata_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   localparam logic GRANT_IF  = 1'b0;
   localparam logic GRANT_LSU = 1'b1;

   // Registered state
   state_t                r_state;
   logic                  r_lastGrant;
   logic [2:0]            r_beat;
   logic                  r_restart;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [31:0]           r_wdata;
   logic [2:0]            r_nBytes;
   logic [31:0]           r_buf;
   logic [ADDR_WIDTH-1:0] r_memA;
   logic [7:0]            r_memDout;
   logic                  r_memWr;
   logic                  r_ifDone;
   logic [31:0]           r_ifData;
   logic                  r_lsuDone;
   logic [31:0]           r_lsuRdata;

   // Combinational helpers and next values
   state_t                w_stateNxt;
   logic                  w_grantIf;
   logic                  w_grantLsu;
   logic                  w_anyGrant;
   logic                  w_flushFetch;
   logic [2:0]            w_lsuNBytes;
   logic                  w_moreToIssue;
   logic                  w_lastRdBeat;
   logic [1:0]            w_capIdx;
   logic [1:0]            w_wrIdx;
   logic [31:0]           w_bufCap;
   logic [7:0]            w_nextWrByte;
   logic                  w_lastGrantNxt;
   logic [2:0]            w_beatNxt;
   logic                  w_restartNxt;
   logic [ADDR_WIDTH-1:0] w_baseNxt;
   logic [31:0]           w_wdataNxt;
   logic [2:0]            w_nBytesNxt;
   logic [31:0]           w_bufNxt;
   logic [ADDR_WIDTH-1:0] w_memANxt;
   logic [7:0]            w_memDoutNxt;
   logic                  w_memWrNxt;
   logic                  w_ifDoneNxt;
   logic [31:0]           w_ifDataNxt;
   logic                  w_lsuDoneNxt;
   logic [31:0]           w_lsuRdataNxt;

   // Round-robin arbitration: a lone request is always granted; when both
   // are present the requester that was not served last wins.
   assign w_grantIf    = if_req_in  && (!lsu_req_in || (r_lastGrant == GRANT_LSU));
   assign w_grantLsu   = lsu_req_in && (!if_req_in  || (r_lastGrant == GRANT_IF));
   assign w_anyGrant   = w_grantIf || w_grantLsu;

   // A flush only matters while the fetch owns a read in progress.
   assign w_flushFetch = (r_state == S_RD) && (r_lastGrant == GRANT_IF) && if_flush_in;

   // The reserved size code is handled as a full word.
   assign w_lsuNBytes  = (lsu_size_in == 2'd0) ? 3'd1 :
                         (lsu_size_in == 2'd1) ? 3'd2 : 3'd4;

   // r_beat counts cycles since the address phase started. In a read the
   // byte arriving on mem_din belongs to beat-1, because RAM answers one
   // cycle after the address was presented.
   assign w_moreToIssue = (r_beat + 3'd1) < r_nBytes;
   assign w_lastRdBeat  = (r_beat == r_nBytes);
   assign w_capIdx      = 2'(r_beat - 3'd1);
   assign w_wrIdx       = 2'(r_beat + 3'd1);
   assign w_nextWrByte  = r_wdata[{w_wrIdx, 3'b000} +: 8];

   // Read buffer with the byte currently on mem_din merged into its lane.
   // The buffer is cleared when a transfer starts, so unused upper lanes
   // stay zero and short loads come out zero-extended.
   always_comb begin
      w_bufCap = r_buf;
      w_bufCap[{w_capIdx, 3'b000} +: 8] = mem_din;
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNxt;
      end
   end

   // Next-state logic. A stall (rdy_in low) holds the current state; the
   // restart flag then replays the transfer from byte 0 once the bus
   // returns. A flush of the fetch overrides a simultaneous stall.
   always_comb begin
      w_stateNxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (rdy_in && w_anyGrant) begin
               w_stateNxt = (w_grantLsu && lsu_wr_in) ? S_WR : S_RD;
            end
         end
         S_RD: begin
            if (w_flushFetch) begin
               w_stateNxt = S_IDLE;
            end else if (rdy_in && !r_restart && w_lastRdBeat) begin
               w_stateNxt = S_DONE;
            end
         end
         S_WR: begin
            if (rdy_in && !r_restart && !w_moreToIssue) begin
               w_stateNxt = S_DONE;
            end
         end
         S_DONE: begin
            w_stateNxt = S_IDLE;
         end
         default: begin
            w_stateNxt = S_IDLE;
         end
      endcase
   end

   // Output / datapath next values. Every bus and handshake output is a
   // register, so this block decides what each register holds next cycle.
   // Done pulses default low, so each one lasts exactly one cycle.
   always_comb begin
      w_lastGrantNxt = r_lastGrant;
      w_beatNxt      = r_beat;
      w_restartNxt   = r_restart;
      w_baseNxt      = r_base;
      w_wdataNxt     = r_wdata;
      w_nBytesNxt    = r_nBytes;
      w_bufNxt       = r_buf;
      w_memANxt      = r_memA;
      w_memDoutNxt   = r_memDout;
      w_memWrNxt     = r_memWr;
      w_ifDoneNxt    = 1'b0;
      w_ifDataNxt    = r_ifData;
      w_lsuDoneNxt   = 1'b0;
      w_lsuRdataNxt  = r_lsuRdata;
      case (r_state)
         S_IDLE: begin
            if (rdy_in && w_anyGrant) begin
               w_lastGrantNxt = w_grantLsu ? GRANT_LSU : GRANT_IF;
               w_baseNxt      = w_grantLsu ? lsu_addr_in : if_addr_in;
               w_wdataNxt     = lsu_wdata_in;
               w_nBytesNxt    = w_grantLsu ? w_lsuNBytes : 3'd4;
               w_beatNxt      = 3'd0;
               w_restartNxt   = 1'b0;
               w_bufNxt       = 32'd0;
               w_memANxt      = w_grantLsu ? lsu_addr_in : if_addr_in;
               w_memWrNxt     = w_grantLsu && lsu_wr_in;
               if (w_grantLsu && lsu_wr_in) begin
                  w_memDoutNxt = lsu_wdata_in[7:0];
               end
            end
         end
         S_RD: begin
            if (w_flushFetch) begin
               w_beatNxt    = 3'd0;
               w_restartNxt = 1'b0;
            end else if (!rdy_in) begin
               w_beatNxt    = 3'd0;
               w_restartNxt = 1'b1;
               w_bufNxt     = 32'd0;
            end else if (r_restart) begin
               w_restartNxt = 1'b0;
               w_beatNxt    = 3'd0;
               w_bufNxt     = 32'd0;
               w_memANxt    = r_base;
            end else begin
               if (r_beat != 3'd0) begin
                  w_bufNxt = w_bufCap;
               end
               if (w_moreToIssue) begin
                  w_memANxt = r_memA + ADDR_WIDTH'(1);
               end
               w_beatNxt = r_beat + 3'd1;
               if (w_lastRdBeat) begin
                  if (r_lastGrant == GRANT_LSU) begin
                     w_lsuDoneNxt  = 1'b1;
                     w_lsuRdataNxt = w_bufCap;
                  end else begin
                     w_ifDoneNxt = 1'b1;
                     w_ifDataNxt = w_bufCap;
                  end
               end
            end
         end
         S_WR: begin
            if (!rdy_in) begin
               w_memWrNxt   = 1'b0;
               w_beatNxt    = 3'd0;
               w_restartNxt = 1'b1;
            end else if (r_restart) begin
               w_restartNxt = 1'b0;
               w_beatNxt    = 3'd0;
               w_memANxt    = r_base;
               w_memWrNxt   = 1'b1;
               w_memDoutNxt = r_wdata[7:0];
            end else if (w_moreToIssue) begin
               w_beatNxt    = r_beat + 3'd1;
               w_memANxt    = r_memA + ADDR_WIDTH'(1);
               w_memDoutNxt = w_nextWrByte;
            end else begin
               w_memWrNxt   = 1'b0;
               w_lsuDoneNxt = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath and output registers. Reset leaves last_grant on the LSU so
   // the fetch wins the first contested arbitration.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_lastGrant <= GRANT_LSU;
         r_beat      <= 3'd0;
         r_restart   <= 1'b0;
         r_base      <= '0;
         r_wdata     <= 32'd0;
         r_nBytes    <= 3'd0;
         r_buf       <= 32'd0;
         r_memA      <= '0;
         r_memDout   <= 8'd0;
         r_memWr     <= 1'b0;
         r_ifDone    <= 1'b0;
         r_ifData    <= 32'd0;
         r_lsuDone   <= 1'b0;
         r_lsuRdata  <= 32'd0;
      end else begin
         r_lastGrant <= w_lastGrantNxt;
         r_beat      <= w_beatNxt;
         r_restart   <= w_restartNxt;
         r_base      <= w_baseNxt;
         r_wdata     <= w_wdataNxt;
         r_nBytes    <= w_nBytesNxt;
         r_buf       <= w_bufNxt;
         r_memA      <= w_memANxt;
         r_memDout   <= w_memDoutNxt;
         r_memWr     <= w_memWrNxt;
         r_ifDone    <= w_ifDoneNxt;
         r_ifData    <= w_ifDataNxt;
         r_lsuDone   <= w_lsuDoneNxt;
         r_lsuRdata  <= w_lsuRdataNxt;
      end
   end

   assign mem_a         = r_memA;
   assign mem_dout      = r_memDout;
   assign mem_wr        = r_memWr;
   assign if_done_out   = r_ifDone;
   assign if_data_out   = r_ifData;
   assign lsu_done_out  = r_lsuDone;
   assign lsu_rdata_out = r_lsuRdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//   Self-checking bench for mem_ctrl. A byte RAM with one cycle of read
//   latency sits on the memory port. A shadow copy of that RAM, updated at
//   transaction level, supplies expected load/fetch data. Expected bus
//   addresses, beat counts, done latencies and arbitration order are derived
//   from the transfer rules, not from the controller's internals.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

   logic        clk;
   logic        rstN;
   logic        rdy;
   logic [7:0]  memDin;
   logic [7:0]  memDout;
   logic [31:0] memA;
   logic        memWr;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic        ifFlush;
   logic        ifDone;
   logic [31:0] ifData;
   logic        lsuReq;
   logic        lsuWr;
   logic [1:0]  lsuSize;
   logic [31:0] lsuAddr;
   logic [31:0] lsuWdata;
   logic        lsuDone;
   logic [31:0] lsuRdata;

   int          testsRun;
   int          testsFailed;
   bit          mLastLsu;

   logic [7:0]  ram    [0:4095];
   logic [7:0]  shadow [0:4095];

   mem_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk_in        (clk),
      .rst_n_in      (rstN),
      .rdy_in        (rdy),
      .mem_din       (memDin),
      .mem_dout      (memDout),
      .mem_a         (memA),
      .mem_wr        (memWr),
      .if_req_in     (ifReq),
      .if_addr_in    (ifAddr),
      .if_flush_in   (ifFlush),
      .if_done_out   (ifDone),
      .if_data_out   (ifData),
      .lsu_req_in    (lsuReq),
      .lsu_wr_in     (lsuWr),
      .lsu_size_in   (lsuSize),
      .lsu_addr_in   (lsuAddr),
      .lsu_wdata_in  (lsuWdata),
      .lsu_done_out  (lsuDone),
      .lsu_rdata_out (lsuRdata)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Power-on / reset contents of every RAM location.
   function automatic logic [7:0] initByte(input logic [11:0] idx);
      return idx[7:0] ^ {idx[11:8], idx[11:8]} ^ 8'h3C;
   endfunction

   // Synchronous RAM seen by the controller: one cycle read latency, the
   // low 12 address bits select the byte, and contents return to the known
   // pattern whenever reset is held across a clock edge.
   always @(posedge clk) begin
      if (!rstN) begin
         for (int i = 0; i < 4096; i++) ram[i] <= initByte(12'(i));
      end else if (memWr) begin
         ram[memA[11:0]] <= memDout;
      end
      memDin <= ram[memA[11:0]];
   end

   // Watchdog so a hung controller still ends the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic resetShadow();
      for (int i = 0; i < 4096; i++) shadow[i] = initByte(12'(i));
   endtask

   function automatic int sizeBytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] expectRead(input logic [31:0] a, input int n);
      logic [31:0] r;
      logic [31:0] ak;
      r = 32'd0;
      for (int k = 0; k < n; k++) begin
         ak = a + 32'(k);
         r[8*k +: 8] = shadow[ak[11:0]];
      end
      return r;
   endfunction

   // One isolated transfer: kind 0 = fetch, 1 = load, 2 = store. Checks the
   // address/data of every beat, the done latency and the returned data.
   task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wdata);
      int          n;
      int          doneAt;
      bit          isWr;
      logic [31:0] expData;
      logic [31:0] ak;
      n       = (kind == 0) ? 4 : sizeBytes(size);
      isWr    = (kind == 2);
      expData = expectRead(addr, n);
      @(posedge clk);
      @(negedge clk);
      if (kind == 0) begin
         ifReq  = 1'b1;
         ifAddr = addr;
      end else begin
         lsuReq   = 1'b1;
         lsuWr    = isWr;
         lsuSize  = size;
         lsuAddr  = addr;
         lsuWdata = wdata;
      end
      doneAt = 0;
      for (int i = 1; i <= n + 4 && doneAt == 0; i++) begin
         @(posedge clk);
         #1;
         if (i <= n) begin
            checkOutput("beatAddr", memA, addr + 32'(i - 1));
            checkOutput("beatWr", 32'(memWr), 32'(isWr));
            if (isWr) checkOutput("beatData", 32'(memDout), 32'(wdata[8*(i-1) +: 8]));
         end
         if ((kind == 0) ? ifDone : lsuDone) doneAt = i;
      end
      ifReq  = 1'b0;
      lsuReq = 1'b0;
      checkOutput("doneLatency", 32'(doneAt), 32'(isWr ? n + 1 : n + 2));
      if (isWr) begin
         checkOutput("doneWrLow", 32'(memWr), 32'd0);
         for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            shadow[ak[11:0]] = wdata[8*k +: 8];
         end
      end else if (kind == 0) begin
         checkOutput("fetchData", ifData, expData);
      end else begin
         checkOutput("loadData", lsuRdata, expData);
      end
      mLastLsu = (kind != 0);
   endtask

   // Fetch and load requested in the same cycle: the one not served last
   // goes first, the other is granted straight after the first DONE.
   task automatic runBoth(input logic [31:0] fAddr, input logic [31:0] lAddr, input logic [1:0] lSize);
      logic [31:0] fExp;
      logic [31:0] lExp;
      int          nL;
      int          fDone;
      int          lDone;
      bit          ifFirst;
      nL      = sizeBytes(lSize);
      fExp    = expectRead(fAddr, 4);
      lExp    = expectRead(lAddr, nL);
      ifFirst = mLastLsu;
      @(posedge clk);
      @(negedge clk);
      ifReq   = 1'b1;
      ifAddr  = fAddr;
      lsuReq  = 1'b1;
      lsuWr   = 1'b0;
      lsuSize = lSize;
      lsuAddr = lAddr;
      fDone   = 0;
      lDone   = 0;
      for (int i = 1; i <= 30 && (fDone == 0 || lDone == 0); i++) begin
         @(posedge clk);
         #1;
         if (ifDone && fDone == 0) begin
            fDone = i;
            checkOutput("bothFetchData", ifData, fExp);
            ifReq = 1'b0;
         end
         if (lsuDone && lDone == 0) begin
            lDone = i;
            checkOutput("bothLoadData", lsuRdata, lExp);
            lsuReq = 1'b0;
         end
      end
      ifReq  = 1'b0;
      lsuReq = 1'b0;
      if (ifFirst) begin
         checkOutput("bothFetchAt", 32'(fDone), 32'd6);
         checkOutput("bothLoadAt", 32'(lDone), 32'(6 + 1 + nL + 2));
      end else begin
         checkOutput("bothLoadAt", 32'(lDone), 32'(nL + 2));
         checkOutput("bothFetchAt", 32'(fDone), 32'(nL + 2 + 1 + 6));
      end
      mLastLsu = ifFirst;
   endtask

   // Word load with rdy low through cycles 3..5 (beat 2 on the bus). The
   // cycle rdy returns counts as a fresh request cycle.
   task automatic stallTest(input logic [31:0] a);
      logic [31:0] expData;
      int          doneCnt;
      int          doneAt;
      expData = expectRead(a, 4);
      @(posedge clk);
      @(negedge clk);
      lsuReq  = 1'b1;
      lsuWr   = 1'b0;
      lsuSize = 2'd2;
      lsuAddr = a;
      doneCnt = 0;
      doneAt  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (lsuDone) begin
            doneCnt++;
            if (doneAt == 0) begin
               doneAt = i;
               checkOutput("stallData", lsuRdata, expData);
            end
            lsuReq = 1'b0;
         end
         if (i == 3) begin
            checkOutput("stallBeat2Addr", memA, a + 32'd2);
            rdy = 1'b0;
         end
         if (i == 6) rdy = 1'b1;
         if (i == 7) checkOutput("restartAddr", memA, a);
         if (i == 8) checkOutput("restartAddr1", memA, a + 32'd1);
      end
      rdy    = 1'b1;
      lsuReq = 1'b0;
      checkOutput("stallDoneCount", 32'(doneCnt), 32'd1);
      checkOutput("stallDoneAt", 32'(doneAt), 32'd12);
      mLastLsu = 1'b1;
   endtask

   // Fetch flushed while its last address is on the bus; a load that was
   // waiting must be granted in the IDLE cycle that follows.
   task automatic flushTest(input logic [31:0] fAddr, input logic [31:0] lAddr);
      logic [31:0] lExp;
      bit          ifSeen;
      int          lDone;
      lExp   = expectRead(lAddr, 1);
      ifSeen = 1'b0;
      lDone  = 0;
      @(posedge clk);
      @(negedge clk);
      ifReq  = 1'b1;
      ifAddr = fAddr;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (ifDone) ifSeen = 1'b1;
         if (lsuDone && lDone == 0) begin
            lDone = i;
            checkOutput("flushLoadData", lsuRdata, lExp);
            lsuReq = 1'b0;
         end
         if (i == 1) begin
            lsuReq  = 1'b1;
            lsuWr   = 1'b0;
            lsuSize = 2'd0;
            lsuAddr = lAddr;
         end
         if (i == 4) begin
            checkOutput("flushBeat3Addr", memA, fAddr + 32'd3);
            ifFlush = 1'b1;
         end
         if (i == 5) begin
            ifFlush = 1'b0;
            ifReq   = 1'b0;
         end
         if (i == 6) checkOutput("flushLoadAddr", memA, lAddr);
      end
      lsuReq = 1'b0;
      checkOutput("flushNoIfDone", 32'(ifSeen), 32'd0);
      checkOutput("flushLoadAt", 32'(lDone), 32'd8);
      mLastLsu = 1'b1;
   endtask

   // Asynchronous reset in the middle of a word store.
   task automatic resetMidWrite(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      @(negedge clk);
      lsuReq   = 1'b1;
      lsuWr    = 1'b1;
      lsuSize  = 2'd2;
      lsuAddr  = a;
      lsuWdata = d;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("preResetWr", 32'(memWr), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("rstWr", 32'(memWr), 32'd0);
      checkOutput("rstAddr", memA, 32'd0);
      checkOutput("rstDout", 32'(memDout), 32'd0);
      checkOutput("rstLsuDone", 32'(lsuDone), 32'd0);
      lsuReq = 1'b0;
      lsuWr  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      resetShadow();
      mLastLsu = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          kind;
      rstN        = 1'b0;
      rdy         = 1'b1;
      ifReq       = 1'b0;
      ifAddr      = 32'd0;
      ifFlush     = 1'b0;
      lsuReq      = 1'b0;
      lsuWr       = 1'b0;
      lsuSize     = 2'd0;
      lsuAddr     = 32'd0;
      lsuWdata    = 32'd0;
      testsRun    = 0;
      testsFailed = 0;
      resetShadow();
      mLastLsu = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetMemA", memA, 32'd0);
      checkOutput("resetMemWr", 32'(memWr), 32'd0);
      checkOutput("resetMemDout", 32'(memDout), 32'd0);
      checkOutput("resetIfDone", 32'(ifDone), 32'd0);
      checkOutput("resetLsuDone", 32'(lsuDone), 32'd0);
      checkOutput("resetIfData", ifData, 32'd0);
      checkOutput("resetLsuData", lsuRdata, 32'd0);
      @(negedge clk);
      rstN = 1'b1;

      runBoth(32'h100, 32'h1000, 2'd0);
      applyStimulus(2, 32'h200, 2'd2, 32'hDEADBEEF);
      applyStimulus(2, 32'h100, 2'd2, 32'h00000513);
      applyStimulus(0, 32'h100, 2'd0, 32'd0);
      checkOutput("fetch0x100", ifData, 32'h00000513);
      runBoth(32'h104, 32'h203, 2'd1);
      runBoth(32'h108, 32'h201, 2'd2);
      stallTest(32'h200);
      checkOutput("stallWord", lsuRdata, 32'hDEADBEEF);
      flushTest(32'h300, 32'h201);
      applyStimulus(2, 32'hFFFF_FFFE, 2'd2, 32'h11223344);
      applyStimulus(1, 32'hFFFF_FFFE, 2'd3, 32'd0);

      for (int t = 0; t < 40; t++) begin
         kind = int'($urandom_range(0, 2));
         sz   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else                           a = 32'h300 + 32'($urandom_range(0, 63));
         if (kind == 0) a = a & ~32'h3;
         applyStimulus(kind, a, sz, $urandom);
         if (t % 8 == 7) runBoth(32'h300 + 32'(4 * $urandom_range(0, 15)), 32'h300 + 32'($urandom_range(0, 63)), sz);
      end

      resetMidWrite(32'h400, 32'hCAFEF00D);
      applyStimulus(1, 32'h400, 2'd2, 32'd0);
      runBoth(32'h404, 32'h402, 2'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
